// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the mem_responder slice.
//   MEM_ADDR_W / MEM_DATA_W : default address / data widths
//   mem_state_e             : responder FSM states
//   addr_t / data_t         : default-width address / data types
package mem_pkg;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 16;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_e;
    typedef logic [MEM_ADDR_W-1:0] addr_t;
    typedef logic [MEM_DATA_W-1:0] data_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W register file with async clear.
//   i_clk, i_rst_n          : clock, async active-low clear of every word
//   i_we, i_waddr, i_wdata  : synchronous write port; out-of-range writes are dropped
//   i_raddr -> o_rdata      : combinational read port; out-of-range reads return 0
module mem_array #(
    parameter int ADDR_W = mem_pkg::MEM_ADDR_W,
    parameter int DATA_W = mem_pkg::MEM_DATA_W,
    parameter int DEPTH  = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_ok;
    logic              w_rd_ok;
    // Only the low index bits address the array; the full address gates access
    // so that an out-of-range address never aliases onto a real word.
    assign w_wr_ok = 32'(i_waddr) < DEPTH;
    assign w_rd_ok = 32'(i_raddr) < DEPTH;
    assign o_rdata = w_rd_ok ? r_mem[i_raddr[IDX_W-1:0]] : '0;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we && w_wr_ok) begin
            r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: bus responder with register-file store, wait states and one-cycle READY.
//   clk, RST_n       : clock, async active-low reset (aborts any transaction)
//   SEL, WR_RDbar    : request valid, 1 = write / 0 = read
//   ADDR, WDATA      : request address and write data, latched on accept
//   READY            : registered one-cycle completion pulse
//   RDATA            : registered read data, updated only on read completion
module mem_responder #(
    parameter int ADDR_W      = mem_pkg::MEM_ADDR_W,
    parameter int DATA_W      = mem_pkg::MEM_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              RST_n,
    input  logic              SEL,
    input  logic              WR_RDbar,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              READY,
    output logic [DATA_W-1:0] RDATA
);
    import mem_pkg::*;
    mem_state_e        r_state;
    logic [3:0]        r_cnt;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_go;
    logic [DATA_W-1:0] w_rdata;
    // Every accepted request passes through WAIT with the counter loaded to
    // WAIT_CYCLES, so READY rises WAIT_CYCLES+1 edges after the accepting edge
    // and a transaction occupies 3+WAIT_CYCLES cycles including the RESP cycle.
    assign w_go = (r_state == WAIT) && SEL && (r_cnt == 4'd0);
    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .i_clk   (clk),
        .i_rst_n (RST_n),
        .i_we    (w_go && r_wr),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            READY   <= 1'b0;
            RDATA   <= '0;
        end else begin
            READY <= w_go;
            if (w_go && !r_wr) RDATA <= w_rdata;
            case (r_state)
                IDLE: if (SEL) begin
                    r_wr    <= WR_RDbar;
                    r_addr  <= ADDR;
                    r_wdata <= WDATA;
                    r_cnt   <= 4'(WAIT_CYCLES);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!SEL) r_state <= IDLE;
                    else if (r_cnt == 4'd0) r_state <= RESP;
                    else r_cnt <= r_cnt - 4'd1;
                end
                // SEL is still high here; returning to IDLE without sampling it
                // keeps the finished request from being accepted twice.
                RESP: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench over three responder configurations.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sel;
    logic        wr_rd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [2:0]  w_ready;
    logic [15:0] w_rdata [3];
    logic [15:0] model [3][256];
    logic [15:0] exp_q [$];
    int          vec = 0;
    int          mis = 0;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .RST_n(rst_n), .SEL(sel[0]), .WR_RDbar(wr_rd), .ADDR(addr),
        .WDATA(wdata), .READY(w_ready[0]), .RDATA(w_rdata[0]));
    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .RST_n(rst_n), .SEL(sel[1]), .WR_RDbar(wr_rd), .ADDR(addr),
        .WDATA(wdata), .READY(w_ready[1]), .RDATA(w_rdata[1]));
    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(128), .WAIT_CYCLES(2)) u_oor (
        .clk(clk), .RST_n(rst_n), .SEL(sel[2]), .WR_RDbar(wr_rd), .ADDR(addr),
        .WDATA(wdata), .READY(w_ready[2]), .RDATA(w_rdata[2]));

    initial forever #5 clk = ~clk;

    function automatic int wt_of(input int d);
        return (d == 1) ? 0 : 2;
    endfunction

    function automatic int dep_of(input int d);
        return (d == 2) ? 128 : 256;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 256; a++) model[d][a] = 16'h0;
    endtask

    // Called #1 after a posedge; returns #1 after the RESP->IDLE edge with SEL low.
    task automatic txn(input int d, input bit wr, input logic [7:0] a, input logic [15:0] wd);
        int n;
        bit seen;
        logic [15:0] exp;
        exp = 16'h0;
        if (wr) begin
            if (int'(a) < dep_of(d)) model[d][a] = wd;
        end else begin
            exp_q.push_back(int'(a) < dep_of(d) ? model[d][a] : 16'h0);
        end
        sel[d] = 1'b1;
        wr_rd = wr;
        addr = a;
        wdata = wd;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = w_ready[d];
        end
        vec++;
        if (!seen || n != wt_of(d) + 2) begin
            mis++;
            $display("FAIL latency dev%0d addr %h: got %0d edges (ready seen=%0b), want %0d", d, a, n, seen, wt_of(d) + 2);
        end
        if (!wr) begin
            exp = exp_q.pop_front();
            vec++;
            if (w_rdata[d] !== exp) begin
                mis++;
                $display("FAIL rdata dev%0d addr %h: got %h, want %h", d, a, w_rdata[d], exp);
            end
        end
        @(posedge clk);
        #1;
        sel[d] = 1'b0;
        vec++;
        if (w_ready[d] !== 1'b0) begin
            mis++;
            $display("FAIL ready_width dev%0d addr %h: got %b, want 0", d, a, w_ready[d]);
        end
    endtask

    task automatic check_quiet(input int d, input string tag);
        bit any;
        any = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any |= w_ready[d];
        end
        vec++;
        if (any) begin
            mis++;
            $display("FAIL %s dev%0d: got READY=1, want READY=0", tag, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel = 3'b000;
        wr_rd = 1'b0;
        addr = 8'h0;
        wdata = 16'h0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vec++;
            if (w_ready[d] !== 1'b0 || w_rdata[d] !== 16'h0) begin
                mis++;
                $display("FAIL reset dev%0d: got ready=%b rdata=%h, want ready=0 rdata=0000", d, w_ready[d], w_rdata[d]);
            end
        end
        @(posedge clk);
        #1;
        txn(0, 1'b0, 8'h10, 16'h0);
    endtask

    task automatic test_write_read();
        txn(0, 1'b1, 8'h3C, 16'hA5A5);
        txn(0, 1'b0, 8'h3C, 16'h0);
        txn(0, 1'b1, 8'h3D, 16'h5555);
        vec++;
        if (w_rdata[0] !== 16'hA5A5) begin
            mis++;
            $display("FAIL rdata_hold dev0: got %h, want a5a5", w_rdata[0]);
        end
        check_quiet(0, "idle_after_rw");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) txn(1, 1'b1, 8'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) txn(1, 1'b0, 8'(i), 16'h0);
        check_quiet(1, "idle_after_b2b");
    endtask

    task automatic test_abort();
        sel[0] = 1'b1;
        wr_rd = 1'b1;
        addr = 8'h20;
        wdata = 16'hBEEF;
        @(posedge clk);
        @(posedge clk);
        #1;
        sel[0] = 1'b0;
        check_quiet(0, "abort_ready");
        txn(0, 1'b0, 8'h20, 16'h0);
    endtask

    task automatic test_out_of_range();
        txn(2, 1'b1, 8'h10, 16'h5A5A);
        txn(2, 1'b1, 8'h90, 16'hFFFF);
        txn(2, 1'b0, 8'h90, 16'h0);
        txn(2, 1'b0, 8'h10, 16'h0);
    endtask

    task automatic test_async_reset();
        txn(0, 1'b1, 8'h05, 16'h0777);
        sel[0] = 1'b1;
        wr_rd = 1'b1;
        addr = 8'h05;
        wdata = 16'h1234;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sel[0] = 1'b0;
        #1;
        rst_n = 1'b1;
        clear_model();
        check_quiet(0, "reset_abort_ready");
        txn(0, 1'b0, 8'h05, 16'h0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_abort();
        test_out_of_range();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
